bcd_batch_accumulator: RTL and testbench
========================================

Name: bcd_batch_accumulator

Overview:
- Consumer stage that receives two-digit BCD sums (x1 = tens, x0 = units) from the base-10 adder stage over the dav_/rfd handshake.
- Accumulates N accepted samples into a 4-digit BCD total.
- Presents the total, with overflow and error flags, to a downstream consumer D over a second dav_/rfd handshake, then clears and starts the next batch.

Parameters:
- N, 4, number of samples per batch; legal range 1..1023.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- davC_  in  1  upstream data valid, active low.
- rfdC  out  1  ready-for-data to upstream.
- x1  in  4  upstream tens digit (BCD).
- x0  in  4  upstream units digit (BCD).
- davD_  out  1  downstream data valid, active low.
- rfdD  in  1  downstream ready-for-data.
- t3,t2,t1,t0  out  4 each  batch total, BCD digits, t3 most significant.
- ovf  out  1  batch total exceeded 9999 (wrapped).
- err  out  1  batch contained at least one illegal digit.

Behaviour:
- Reset: sampled only on posedge clock while reset==1, overriding any state. Next-state values:
  - rfdC=1, davD_=1.
  - t3..t0=0, ovf=0, err=0.
  - accumulator=0, count=0, state=S_WAIT.
- Reset mid-batch or mid-output: partial sums are discarded.
- Internal registers:
  - acc: 4 BCD digits.
  - cnt: 10 bits.
  - ovf_r, err_r: sticky flags.
  - t3..t0, ovf, err: output registers, loaded only when a batch completes.
- Per-digit BCD add: acc + {0,0,x1,x0}, ripple decimal carry; each digit sum s>9 gives s-10 with carry 1. Carry out of digit 3 sets ovf_r; acc keeps the sum mod 10000.
- Legal input: x1<=9 and x0<=9.
- Illegal input: the handshake still completes, the sample is NOT added and NOT counted, and err_r<=1.
- FSM, 2-bit state:
  - S_WAIT (rfdC=1): on edge with davC_==0:
    - legal sample: acc<=acc+sample, cnt<=cnt+1.
    - always: rfdC<=0, go to S_ACK.
  - S_ACK (rfdC=0): wait davC_==1. Then:
    - if cnt==N: load t3..t0<=acc, ovf<=ovf_r, err<=err_r; davD_<=0; rfdC stays 0; go to S_OUT.
    - else: rfdC<=1, go to S_WAIT.
  - S_OUT (davD_=0): on rfdD==0, davD_<=1, go to S_END.
  - S_END: on rfdD==1: acc<=0, cnt<=0, ovf_r<=0, err_r<=0, rfdC<=1, go to S_WAIT. t3..t0/ovf/err hold their values until the next batch load.
- Timing and handshake rules:
  - davC_ held low for many cycles counts exactly once.
  - While in S_OUT/S_END, upstream is blocked (rfdC=0) and davC_ is ignored.
  - Minimum latency from the last davC_ rising edge to the davD_ falling edge is 1 clock.
  - Outputs are stable whenever davD_==0.
- Boundary cases:
  - An illegal sample on what would be the N-th slot does not complete the batch.
  - N=1: every legal sample produces an output transfer.
  - cnt never exceeds N.

Test Plan:
1. N=4; send 18,18,18,18, each with a full handshake -> after the 4th davC_ rise, davD_=0 with t=0,0,7,2, ovf=0, err=0; exactly one downstream transfer.
2. N=3; send 09,09,09 -> t=0,0,2,7. Then a second batch 01,00,00 -> t=0,0,0,1, confirming clear between batches.
3. N=600; 600 samples of 18 -> total 10800 reported as t=0,8,0,0 with ovf=1. The next batch of 600 samples of 00 -> ovf=0.
4. N=2; send x1=0,x0=12, then 05, then 03 -> err=1, t=0,0,0,8. The illegal sample is handshaken (rfdC dropped) but not counted.
5. N=1; hold rfdD=1 for 10 cycles after davD_ falls -> davD_ stays 0, rfdC stays 0, and a davC_=0 pulse meanwhile is ignored. After rfdD 1->0->1, rfdC returns to 1.
6. N=4; after 2 samples, assert reset for 1 cycle -> rfdC=1, davD_=1, outputs 0. The next 4 samples of 01 -> t=0,0,0,4.

Source files
------------

// File: rtl/bcd_batch_accumulator.sv
// rtl/bcd_batch_accumulator.sv - sums N two-digit BCD samples into a 4-digit total
// and hands each batch total downstream over a dav_/rfd handshake.
module bcd_batch_accumulator #(
  parameter int N = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       davC_,
  output logic       rfdC,
  input  logic [3:0] x1,
  input  logic [3:0] x0,
  output logic       davD_,
  input  logic       rfdD,
  output logic [3:0] t3,
  output logic [3:0] t2,
  output logic [3:0] t1,
  output logic [3:0] t0,
  output logic       ovf,
  output logic       err
);

  typedef enum logic [1:0] {S_WAIT, S_ACK, S_OUT, S_END} state_t;

  localparam logic [9:0] N_CNT = 10'(N);

  state_t      state_q, state_d;
  logic        rfdC_q, rfdC_d;
  logic        davD_q, davD_d;
  logic [15:0] acc_q, acc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        ovf_r_q, ovf_r_d;
  logic        err_r_q, err_r_d;
  logic [15:0] tot_q, tot_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic [4:0]  d0, d1, d2, d3;
  logic [15:0] sum;
  logic        legal;

  // One decimal digit with carry; operands are always legal BCD so s <= 19.
  function automatic logic [4:0] bcd_digit(input logic [3:0] a, input logic [3:0] b,
                                           input logic ci);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    else          return {1'b0, s[3:0]};
  endfunction

  always_comb begin
    d0    = bcd_digit(acc_q[3:0],   x0,   1'b0);
    d1    = bcd_digit(acc_q[7:4],   x1,   d0[4]);
    d2    = bcd_digit(acc_q[11:8],  4'd0, d1[4]);
    d3    = bcd_digit(acc_q[15:12], 4'd0, d2[4]);
    sum   = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
    legal = (x1 <= 4'd9) && (x0 <= 4'd9);
  end

  always_comb begin
    state_d = state_q;
    rfdC_d  = rfdC_q;
    davD_d  = davD_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_r_d = ovf_r_q;
    err_r_d = err_r_q;
    tot_d   = tot_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (!davC_) begin
          if (legal) begin
            acc_d   = sum;
            cnt_d   = cnt_q + 10'd1;
            ovf_r_d = ovf_r_q | d3[4];
          end else begin
            err_r_d = 1'b1;
          end
          rfdC_d  = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (davC_) begin
          if (cnt_q == N_CNT) begin
            tot_d   = acc_q;
            ovf_d   = ovf_r_q;
            err_d   = err_r_q;
            davD_d  = 1'b0;
            state_d = S_OUT;
          end else begin
            rfdC_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_OUT: begin
        if (!rfdD) begin
          davD_d  = 1'b1;
          state_d = S_END;
        end
      end
      S_END: begin
        // Output registers keep the last total; only the working state is cleared.
        if (rfdD) begin
          acc_d   = 16'h0000;
          cnt_d   = 10'd0;
          ovf_r_d = 1'b0;
          err_r_d = 1'b0;
          rfdC_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_WAIT;
      rfdC_q  <= 1'b1;
      davD_q  <= 1'b1;
      acc_q   <= 16'h0000;
      cnt_q   <= 10'd0;
      ovf_r_q <= 1'b0;
      err_r_q <= 1'b0;
      tot_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rfdC_q  <= rfdC_d;
      davD_q  <= davD_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_r_q <= ovf_r_d;
      err_r_q <= err_r_d;
      tot_q   <= tot_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign rfdC  = rfdC_q;
  assign davD_ = davD_q;
  assign t3    = tot_q[15:12];
  assign t2    = tot_q[11:8];
  assign t1    = tot_q[7:4];
  assign t0    = tot_q[3:0];
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_batch_accumulator.sv
// tb/tb_bcd_batch_accumulator.sv - directed checks of bcd_batch_accumulator
// using one instance per batch size (N = 4, 3, 600, 2, 1).
module tb_bcd_batch_accumulator;

  localparam int NU  = 5;
  localparam int LIM = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       davc_n [NU];
  logic       rfdc   [NU];
  logic [3:0] x1     [NU];
  logic [3:0] x0     [NU];
  logic       davd_n [NU];
  logic       rfdd   [NU];
  logic [3:0] t3     [NU];
  logic [3:0] t2     [NU];
  logic [3:0] t1     [NU];
  logic [3:0] t0     [NU];
  logic       ovf    [NU];
  logic       err    [NU];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int NG = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 600 : (g == 3) ? 2 : 1;
    bcd_batch_accumulator #(.N(NG)) u_dut (
      .clock (clock),
      .reset (reset),
      .davC_ (davc_n[g]),
      .rfdC  (rfdc[g]),
      .x1    (x1[g]),
      .x0    (x0[g]),
      .davD_ (davd_n[g]),
      .rfdD  (rfdd[g]),
      .t3    (t3[g]),
      .t2    (t2[g]),
      .t1    (t1[g]),
      .t0    (t0[g]),
      .ovf   (ovf[g]),
      .err   (err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] total(input int u);
    return {t3[u], t2[u], t1[u], t0[u]};
  endfunction

  // Full upstream handshake; returns at the negedge after davC_ rises.
  task automatic send(input int u, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (!rfdc[u] && n < LIM) begin
      @(negedge clock);
      n++;
    end
    if (n >= LIM) check("rfdC_rise_timeout", 0, 1);
    x1[u] = a;
    x0[u] = b;
    davc_n[u] = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rfdc[u] && n < LIM);
    if (n >= LIM) check("rfdC_fall_timeout", 0, 1);
    davc_n[u] = 1'b1;
    @(negedge clock);
  endtask

  // Downstream handshake with output checks, ending with upstream reopened.
  task automatic recv(input int u, input logic [15:0] t_exp, input logic o_exp,
                      input logic e_exp);
    int n;
    n = 0;
    while (davd_n[u] && n < LIM) begin
      @(negedge clock);
      n++;
    end
    if (n >= LIM) check("davD_fall_timeout", 0, 1);
    check("total", 32'(total(u)), 32'(t_exp));
    check("ovf", 32'(ovf[u]), 32'(o_exp));
    check("err", 32'(err[u]), 32'(e_exp));
    rfdd[u] = 1'b0;
    @(negedge clock);
    check("davD_release", 32'(davd_n[u]), 1);
    check("rfdC_blocked_end", 32'(rfdc[u]), 0);
    rfdd[u] = 1'b1;
    @(negedge clock);
    check("rfdC_reopen", 32'(rfdc[u]), 1);
    check("total_hold", 32'(total(u)), 32'(t_exp));
  endtask

  initial begin
    for (int i = 0; i < NU; i++) begin
      davc_n[i] = 1'b1;
      rfdd[i]   = 1'b1;
      x1[i]     = 4'd0;
      x0[i]     = 4'd0;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NU; i++) begin
      check("reset_rfdC", 32'(rfdc[i]), 1);
      check("reset_davD", 32'(davd_n[i]), 1);
      check("reset_total", 32'(total(i)), 0);
      check("reset_flags", 32'({ovf[i], err[i]}), 0);
    end

    // N=4: 4 x 18 = 72, one-clock latency, single transfer
    for (int k = 0; k < 4; k++) send(0, 4'd1, 4'd8);
    check("t1_latency", 32'(davd_n[0]), 0);
    recv(0, 16'h0072, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    check("t1_single_xfer", 32'(davd_n[0]), 1);

    // N=3: 9+9+9 = 27, then 1+0+0 = 1 after clear
    for (int k = 0; k < 3; k++) send(1, 4'd0, 4'd9);
    recv(1, 16'h0027, 1'b0, 1'b0);
    send(1, 4'd0, 4'd1);
    send(1, 4'd0, 4'd0);
    send(1, 4'd0, 4'd0);
    recv(1, 16'h0001, 1'b0, 1'b0);

    // N=600: 600 x 18 = 10800 wraps to 0800 with ovf, then an all-zero batch
    for (int k = 0; k < 599; k++) send(2, 4'd1, 4'd8);
    check("t3_not_done_599", 32'(davd_n[2]), 1);
    send(2, 4'd1, 4'd8);
    recv(2, 16'h0800, 1'b1, 1'b0);
    for (int k = 0; k < 600; k++) send(2, 4'd0, 4'd0);
    recv(2, 16'h0000, 1'b0, 1'b0);

    // N=2: illegal 0/12 is handshaken but not counted
    send(3, 4'd0, 4'd12);
    check("t4_illegal_not_counted", 32'(davd_n[3]), 1);
    check("t4_illegal_rfdC_back", 32'(rfdc[3]), 1);
    send(3, 4'd0, 4'd5);
    check("t4_second_slot_open", 32'(davd_n[3]), 1);
    send(3, 4'd0, 4'd3);
    recv(3, 16'h0008, 1'b0, 1'b1);

    // N=1: output held while rfdD stays high; upstream pulse ignored
    send(4, 4'd0, 4'd7);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        x1[4] = 4'd0;
        x0[4] = 4'd5;
        davc_n[4] = 1'b0;
      end
      if (k == 5) davc_n[4] = 1'b1;
      @(negedge clock);
      check("t5_davD_held", 32'(davd_n[4]), 0);
      check("t5_rfdC_blocked", 32'(rfdc[4]), 0);
    end
    recv(4, 16'h0007, 1'b0, 1'b0);
    @(negedge clock);
    check("t5_pulse_ignored", 32'(davd_n[4]), 1);
    send(4, 4'd0, 4'd2);
    recv(4, 16'h0002, 1'b0, 1'b0);

    // N=4: reset mid-batch discards the partial sum
    send(0, 4'd0, 4'd1);
    send(0, 4'd0, 4'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_rfdC", 32'(rfdc[0]), 1);
    check("t6_davD", 32'(davd_n[0]), 1);
    check("t6_total", 32'(total(0)), 0);
    check("t6_flags", 32'({ovf[0], err[0]}), 0);
    for (int k = 0; k < 4; k++) send(0, 4'd0, 4'd1);
    recv(0, 16'h0004, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
